tdm_demux4: RTL and testbench

4-channel time-division demultiplexer. It is the receive end of a serial TDM link whose transmit end is a 4:1 multiplexer stepping through inputs i0..i3. The block takes a serial bit stream plus a frame-sync marker and deserialises WIDTH-bit slots. Each slot is routed to its own registered channel output (out0..out3) with a one-cycle valid strobe.

---
 rtl/tdm_pkg.sv | 13 +
 rtl/tdm_slot_counter.sv | 41 ++++
 rtl/tdm_demux4.sv | 101 ++++++++++
 tb/tb_tdm_demux4.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM link (mux and demux sides).
package tdm_pkg;

  localparam int unsigned NUM_CH        = 4;
  localparam int unsigned SLOT_W        = 2;
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit/slot position counter for the TDM receiver, with sync-load and boundary flags.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              adv,
  input  logic              load,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic              at_frame_start_c,
  output logic              at_slot_end_c
);

  localparam int unsigned BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [BW-1:0] bit_cnt;

  assign at_slot_end_c    = (bit_cnt == BW'(WIDTH - 1));
  assign at_frame_start_c = (bit_cnt == '0) && (slot_cnt == '0);

  // Load places the counter just past the slot-0 MSB that arrived with the sync.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      slot_cnt <= '0;
    end else if (load) begin
      bit_cnt  <= BW'(1);
      slot_cnt <= '0;
    end else if (adv) begin
      if (at_slot_end_c) begin
        bit_cnt  <= '0;
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end else begin
        bit_cnt  <= bit_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer: frame-sync hunting, slot deserialisation and
// per-channel registered outputs with single-cycle valid strobes.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bit_en,
  input  logic              sin,
  input  logic              frame_sync,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic [NUM_CH-1:0] valid,
  output logic              locked,
  output logic              sync_err
);

  state_e              state;
  logic [WIDTH-1:0]    shift;
  logic [WIDTH-1:0]    out_q [NUM_CH];
  logic [WIDTH-1:0]    word_c;
  logic [SLOT_W-1:0]   slot_cnt;
  logic                at_frame_start_c;
  logic                at_slot_end_c;
  logic                cnt_adv_c;
  logic                cnt_load_c;
  logic                frame_err_c;
  logic                misplaced_c;
  logic                slot_done_c;

  tdm_slot_counter #(.WIDTH(WIDTH)) u_cnt (
    .clock            (clock),
    .reset_n          (reset_n),
    .adv              (cnt_adv_c),
    .load             (cnt_load_c),
    .slot_cnt         (slot_cnt),
    .at_frame_start_c (at_frame_start_c),
    .at_slot_end_c    (at_slot_end_c)
  );

  assign word_c = {shift[WIDTH-2:0], sin};

  // Classify each strobed bit; a misplaced sync takes priority over a slot end.
  always_comb begin
    cnt_adv_c   = 1'b0;
    cnt_load_c  = 1'b0;
    frame_err_c = 1'b0;
    misplaced_c = 1'b0;
    slot_done_c = 1'b0;
    if (bit_en) begin
      if (state == HUNT) begin
        cnt_load_c = frame_sync;
      end else if (at_frame_start_c) begin
        cnt_adv_c   = frame_sync;
        frame_err_c = !frame_sync;
      end else if (frame_sync) begin
        misplaced_c = 1'b1;
        cnt_load_c  = 1'b1;
      end else begin
        cnt_adv_c   = 1'b1;
        slot_done_c = at_slot_end_c;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HUNT;
      shift    <= '0;
      valid    <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) out_q[k] <= '0;
    end else begin
      valid    <= '0;
      sync_err <= frame_err_c | misplaced_c;
      if (frame_err_c) begin
        state  <= HUNT;
        locked <= 1'b0;
      end else if (bit_en && (state == RECEIVE || frame_sync)) begin
        shift  <= word_c;
        state  <= RECEIVE;
        locked <= 1'b1;
      end
      if (slot_done_c) begin
        out_q[slot_cnt] <= word_c;
        valid[slot_cnt] <= 1'b1;
      end
    end
  end

  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed, table-driven bench for tdm_demux4 (WIDTH=8).
module tb_tdm_demux4;

  logic       clock;
  logic       reset_n;
  logic       bit_en;
  logic       sin;
  logic       frame_sync;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] valid;
  logic       locked;
  logic       sync_err;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_out [4];

  tdm_demux4 #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bit_en     (bit_en),
    .sin        (sin),
    .frame_sync (frame_sync),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .valid      (valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // rst: pulse reset before this entry; n: number of MSB-first bits sent;
  // slot: channel expected to complete on the last bit (-1 none); err: sync_err on first bit.
  typedef struct {
    logic       rst;
    logic       fs;
    logic [7:0] b;
    int         n;
    int         slot;
    logic       err;
    logic       lock;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [7:0] exp, input logic [7:0] act);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic s, input logic fs);
    bit_en     = en;
    sin        = s;
    frame_sync = fs;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs();
    chk("out0", exp_out[0], out0);
    chk("out1", exp_out[1], out1);
    chk("out2", exp_out[2], out2);
    chk("out3", exp_out[3], out3);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out0"}, 8'h00, out0);
    chk({tag, "_out1"}, 8'h00, out1);
    chk({tag, "_out2"}, 8'h00, out2);
    chk({tag, "_out3"}, 8'h00, out3);
    chk({tag, "_valid"}, 8'h00, {4'h0, valid});
    chk({tag, "_locked"}, 8'h00, {7'h0, locked});
    chk({tag, "_sync_err"}, 8'h00, {7'h0, sync_err});
  endtask

  // Asynchronous assert between edges, release just after a rising edge.
  task automatic do_reset();
    bit_en     = 1'b0;
    frame_sync = 1'b0;
    sin        = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_state("rst_async");
    @(posedge clock);
    #1;
    check_reset_state("rst_held");
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) exp_out[k] = 8'h00;
  endtask

  task automatic apply(input vec_t v);
    logic [3:0] ev;
    if (v.rst) do_reset();
    for (int i = 0; i < v.n; i++) begin
      step(1'b1, v.b[7-i], (i == 0) ? v.fs : 1'b0);
      ev = 4'h0;
      if (i == v.n - 1 && v.slot >= 0) begin
        ev = 4'(1 << v.slot);
        exp_out[v.slot] = v.b;
      end
      chk("valid", {4'h0, ev}, {4'h0, valid});
      chk("sync_err", {7'h0, (i == 0) ? v.err : 1'b0}, {7'h0, sync_err});
      chk("locked", {7'h0, v.lock}, {7'h0, locked});
    end
    check_outs();
  endtask

  initial begin
    logic [7:0] data;
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    bit_en = 1'b0;
    sin = 1'b0;
    frame_sync = 1'b0;
    for (int k = 0; k < 4; k++) exp_out[k] = 8'h00;

    tbl = '{
      '{1'b0, 1'b1, 8'hA5, 8,  0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h3C, 8,  1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'hF0, 8,  2, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h0F, 8,  3, 1'b0, 1'b1},
      '{1'b0, 1'b1, 8'h11, 8,  0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h22, 8,  1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h33, 8,  2, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h44, 8,  3, 1'b0, 1'b1},
      '{1'b0, 1'b1, 8'h55, 8,  0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h66, 8,  1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h77, 8,  2, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h88, 8,  3, 1'b0, 1'b1},
      '{1'b0, 1'b1, 8'hA5, 8,  0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h3C, 8,  1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'hF0, 8,  2, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h0F, 8,  3, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h00, 8, -1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 8'hFF, 8, -1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'hA5, 8,  0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h3C, 4, -1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 8'h9A, 8,  0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 8'h12, 8,  1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h34, 8,  2, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'h56, 7, -1, 1'b0, 1'b1},
      '{1'b0, 1'b1, 8'hB7, 8,  0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 8'hC8, 8,  1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'hE1, 4, -1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 8'hDE, 8,  0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'hAD, 8,  1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'hBE, 8,  2, 1'b0, 1'b1},
      '{1'b0, 1'b0, 8'hEF, 8,  3, 1'b0, 1'b1}
    };

    repeat (2) @(posedge clock);
    #1;
    check_reset_state("por");
    reset_n = 1'b1;

    for (int v = 0; v < NV; v++) apply(tbl[v]);

    // Sparse bit strobes: idle clocks carry junk sin and a stray frame_sync.
    data = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 2; j++) begin
        step(1'b0, ~data[7-i], 1'b1);
        chk("idle_valid", 8'h00, {4'h0, valid});
        chk("idle_sync_err", 8'h00, {7'h0, sync_err});
      end
      step(1'b1, data[7-i], (i == 0));
      chk("strobe_valid", (i == 7) ? 8'h01 : 8'h00, {4'h0, valid});
      chk("strobe_locked", 8'h01, {7'h0, locked});
    end
    exp_out[0] = 8'hC3;
    check_outs();
    step(1'b0, 1'b0, 1'b0);
    chk("valid_drop", 8'h00, {4'h0, valid});
    check_outs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
